// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MemOp codes, MMIO register offsets and STATUS bit positions
package dmem_pkg;
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  localparam logic [3:0] MMIO_CYCLE  = 4'h0;
  localparam logic [3:0] MMIO_LED    = 4'h4;
  localparam logic [3:0] MMIO_TXDATA = 4'h8;
  localparam logic [3:0] MMIO_STATUS = 4'hC;
  localparam int ST_TX_VALID    = 0;
  localparam int ST_TX_OVERFLOW = 1;
  localparam int ST_MISALIGN    = 2;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_MMIO} src_t;
  // the unsigned codes only exist for loads; as stores they fall back to word
  function automatic size_t op_size(input logic [2:0] op, input logic store);
    if (op == MEMOP_B || (!store && op == MEMOP_BU)) return SZ_B;
    if (op == MEMOP_H || (!store && op == MEMOP_HU)) return SZ_H;
    return SZ_W;
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: byte-lane write-enabled synchronous RAM with registered read
module dmem_ram #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: core data port slave serving RAM loads/stores and the MMIO block
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_WORDS_LOG2 = 14,
  parameter logic [31:0] RAM_BASE       = 32'h0010_0000,
  parameter logic [31:0] MMIO_BASE      = 32'h0020_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write,
  input  logic        data_we,
  input  logic [2:0]  MemOp,
  output logic [31:0] data_read,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam logic [31:0] RAM_BYTES = 32'd4 << RAM_WORDS_LOG2;
  logic [31:0] ram_off, mmio_off, wdat, ram_word, mmio_rd, status, cycle, r_mmio, ram_val;
  logic        is_ram, is_mmio, mis, mmio_wr, tx_wr, tx_accept, st_wr, tx_overflow, misalign, r_uns;
  logic [3:0]  be, ram_we, reg_sel;
  logic [1:0]  r_lane;
  logic [7:0]  bsel;
  logic [15:0] hsel;
  size_t       sz, r_sz;
  src_t        src;
  assign ram_off  = data_addr - RAM_BASE;
  assign mmio_off = data_addr - MMIO_BASE;
  assign is_ram   = ram_off < RAM_BYTES;
  assign is_mmio  = mmio_off < 32'd16;
  assign sz       = op_size(MemOp, data_we);
  assign mis      = (sz == SZ_H && data_addr[0]) || (sz == SZ_W && data_addr[1:0] != 2'b00);
  assign be       = sz == SZ_B ? 4'b0001 << data_addr[1:0] : sz == SZ_H ? (data_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdat     = sz == SZ_B ? {4{data_write[7:0]}} : sz == SZ_H ? {2{data_write[15:0]}} : data_write;
  assign ram_we   = (data_we && is_ram && !mis && !rst) ? be : 4'b0000;
  dmem_ram #(.AW(RAM_WORDS_LOG2)) u_ram (
    .clk   (clk),
    .addr  (ram_off[RAM_WORDS_LOG2+1:2]),
    .we    (ram_we),
    .wdata (wdat),
    .rdata (ram_word)
  );
  // MMIO ignores the access size and always acts on the containing word
  assign reg_sel   = {mmio_off[3:2], 2'b00};
  assign mmio_wr   = data_we && is_mmio && !mis;
  assign tx_wr     = mmio_wr && reg_sel == MMIO_TXDATA;
  assign tx_accept = tx_wr && (!tx_valid || tx_ready);
  assign st_wr     = mmio_wr && reg_sel == MMIO_STATUS;
  assign status    = {29'd0, misalign, tx_overflow, tx_valid};
  assign mmio_rd   = reg_sel == MMIO_CYCLE ? cycle : reg_sel == MMIO_LED ? {16'd0, led} :
                     reg_sel == MMIO_STATUS ? status : 32'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle       <= '0;
      led         <= '0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      tx_overflow <= 1'b0;
      misalign    <= 1'b0;
      src         <= SRC_NONE;
      r_lane      <= '0;
      r_sz        <= SZ_W;
      r_uns       <= 1'b0;
      r_mmio      <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (mmio_wr && reg_sel == MMIO_LED) led <= data_write[15:0];
      if (tx_accept) begin
        tx_data  <= data_write[7:0];
        tx_valid <= 1'b1;
      end else if (tx_ready) tx_valid <= 1'b0;
      tx_overflow <= (tx_wr && !tx_accept) || (tx_overflow && !(st_wr && data_write[ST_TX_OVERFLOW]));
      misalign    <= mis || (misalign && !(st_wr && data_write[ST_MISALIGN]));
      src         <= mis ? SRC_NONE : is_ram ? SRC_RAM : is_mmio ? SRC_MMIO : SRC_NONE;
      r_lane      <= data_addr[1:0];
      r_sz        <= sz;
      r_uns       <= MemOp[2];
      r_mmio      <= mmio_rd;
    end
  end
  assign bsel      = 8'(ram_word >> {r_lane, 3'b000});
  assign hsel      = r_lane[1] ? ram_word[31:16] : ram_word[15:0];
  assign ram_val   = r_sz == SZ_B ? {{24{~r_uns & bsel[7]}}, bsel} :
                     r_sz == SZ_H ? {{16{~r_uns & hsel[15]}}, hsel} : ram_word;
  assign data_read = src == SRC_RAM ? ram_val : src == SRC_MMIO ? r_mmio : 32'd0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed vector table plus hand sequences for console, counter and reset
module tb_data_mem_responder;
  localparam logic [31:0] R = 32'h0010_0000;
  localparam logic [31:0] M = 32'h0020_0000;
  localparam logic [2:0]  W = 3'b010;
  logic        clk = 1'b0, rst = 1'b1, data_we = 1'b0, tx_ready = 1'b0, tx_valid;
  logic [31:0] data_addr = R, data_write = '0, data_read;
  logic [2:0]  MemOp = W;
  logic [15:0] led;
  logic [7:0]  tx_data;
  int          total = 0, bad = 0;
  typedef struct packed {
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t v[$];
  data_mem_responder dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .data_write(data_write), .data_we(data_we),
    .MemOp(MemOp), .data_read(data_read), .led(led), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    data_we = we; MemOp = op; data_addr = a; data_write = wd;
    @(posedge clk); #1;
    data_we = 1'b0; MemOp = W; data_addr = R; data_write = '0;
  endtask
  task automatic add(input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                     input logic chk, input logic [31:0] exp);
    v.push_back({we, op, a, wd, chk, exp});
  endtask
  initial begin
    add(1, W, R+4, 32'h8081_8283, 0, 0);
    add(0, W, R+4, 0, 1, 32'h8081_8283);
    add(0, 3'b000, R+4, 0, 1, 32'hFFFF_FF83);
    add(0, 3'b100, R+7, 0, 1, 32'h0000_0080);
    add(0, 3'b001, R+6, 0, 1, 32'hFFFF_8081);
    add(0, 3'b101, R+4, 0, 1, 32'h0000_8283);
    add(0, 3'b000, R+5, 0, 1, 32'hFFFF_FF82);
    add(0, 3'b100, R+6, 0, 1, 32'h0000_0081);
    add(1, W, R+8, 32'h1122_3344, 0, 0);
    add(1, 3'b000, R+9, 32'h1234_56AA, 0, 0);
    add(1, 3'b001, R+10, 32'hFFFF_BEEF, 0, 0);
    add(0, W, R+8, 0, 1, 32'hBEEF_AA44);
    add(0, 3'b101, R+8, 0, 1, 32'h0000_AA44);
    add(0, 3'b000, R+10, 0, 1, 32'hFFFF_FFEF);
    add(1, W, R+0, 32'h0102_0304, 0, 0);
    add(1, W, R+1, 32'hDEAD_BEEF, 0, 0);
    add(0, W, R+0, 0, 1, 32'h0102_0304);
    add(0, W, M+12, 0, 1, 32'h4);
    add(1, W, M+12, 32'h4, 0, 0);
    add(0, W, M+12, 0, 1, 32'h0);
    add(0, 3'b001, R+3, 0, 1, 32'h0);
    add(0, W, M+12, 0, 1, 32'h4);
    add(1, W, M+12, 32'h2, 0, 0);
    add(0, W, M+12, 0, 1, 32'h4);
    add(1, W, M+12, 32'h4, 0, 0);
    add(0, W, M+12, 0, 1, 32'h0);
    add(1, 3'b011, R+12, 32'hCAFE_F00D, 0, 0);
    add(0, 3'b011, R+12, 0, 1, 32'hCAFE_F00D);
    add(1, 3'b100, R+16, 32'h1111_1111, 0, 0);
    add(0, W, R+16, 0, 1, 32'h1111_1111);
    add(1, W, 32'h0, 32'h5555, 0, 0);
    add(0, W, 32'h0, 0, 1, 32'h0);
    add(0, W, R+0, 0, 1, 32'h0102_0304);
    add(1, W, R+32'hFFFC, 32'h0BAD_F00D, 0, 0);
    add(0, W, R+32'hFFFC, 0, 1, 32'h0BAD_F00D);
    add(1, W, R+32'h1_0000, 32'h99, 0, 0);
    add(0, W, R+32'h1_0000, 0, 1, 32'h0);
    add(0, W, R+0, 0, 1, 32'h0102_0304);
    add(1, W, R+0, 32'hA5A5_A5A5, 1, 32'h0102_0304);
    add(0, W, R+0, 0, 1, 32'hA5A5_A5A5);
    add(0, W, R-4, 0, 1, 32'h0);
    add(0, W, M+16, 0, 1, 32'h0);
    add(1, W, M+4, 32'h0001_ABCD, 0, 0);
    add(0, W, M+4, 0, 1, 32'h0000_ABCD);
    add(0, 3'b100, M+6, 0, 1, 32'h0000_ABCD);
    add(1, 3'b000, M+5, 32'h0000_1234, 0, 0);
    add(0, W, M+4, 0, 1, 32'h0000_1234);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_data_read", data_read, 0);
    check("rst_led", {16'd0, led}, 0);
    check("rst_tx_valid", {31'd0, tx_valid}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    step(0, W, M+0, 0);
    check("cycle0", data_read, 0);
    step(0, W, M+0, 0);
    check("cycle1", data_read, 1);
    step(0, W, M+12, 0);
    check("rst_status", data_read, 0);
    step(1, W, M+4, 32'h0001_ABCD);
    check("led_port", {16'd0, led}, 32'hABCD);
    foreach (v[i]) begin
      step(v[i].we, v[i].op, v[i].addr, v[i].wd);
      if (v[i].chk) check($sformatf("vec%0d", i), data_read, v[i].exp);
    end
    check("led_sub_word", {16'd0, led}, 32'h1234);
    step(1, W, M+8, 32'h41);
    check("tx_first_valid", {31'd0, tx_valid}, 1);
    check("tx_first_data", {24'd0, tx_data}, 32'h41);
    step(1, W, M+8, 32'h42);
    check("tx_hold_data", {24'd0, tx_data}, 32'h41);
    step(0, W, M+12, 0);
    check("tx_ovf_status", data_read, 32'h3);
    tx_ready = 1'b1;
    step(0, W, R, 0);
    tx_ready = 1'b0;
    check("tx_drain", {31'd0, tx_valid}, 0);
    step(1, W, M+12, 32'h2);
    step(0, W, M+12, 0);
    check("ovf_cleared", data_read, 0);
    step(1, W, M+8, 32'h43);
    check("tx_43_data", {24'd0, tx_data}, 32'h43);
    tx_ready = 1'b1;
    step(1, W, M+8, 32'h44);
    tx_ready = 1'b0;
    check("tx_backtoback_valid", {31'd0, tx_valid}, 1);
    check("tx_backtoback_data", {24'd0, tx_data}, 32'h44);
    step(0, W, M+12, 0);
    check("tx_backtoback_status", data_read, 32'h1);
    step(0, W, M+8, 0);
    check("txdata_reads_zero", data_read, 0);
    rst = 1'b1;
    step(1, W, R+0, 32'h1234_5678);
    check("abort_tx_valid", {31'd0, tx_valid}, 0);
    check("abort_tx_data", {24'd0, tx_data}, 0);
    check("abort_led", {16'd0, led}, 0);
    check("abort_data_read", data_read, 0);
    rst = 1'b0;
    step(0, W, R+0, 0);
    check("store_in_reset", data_read, 32'hA5A5_A5A5);
    step(0, W, M+12, 0);
    check("abort_status", data_read, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
